// File: rtl/serv_rf_dbg_arb_if.sv
// Debug-side access port of the RF arbiter: one 32-bit register read or write per request.
// The debug module drives the i_* signals and the arbiter drives the o_* signals.
interface serv_rf_dbg_arb_if #(
  parameter int RF_AW = 6
) ();
  logic             i_dbg_halted;
  logic             i_dbg_req;
  logic             i_dbg_we;
  logic [RF_AW-1:0] i_dbg_addr;
  logic [31:0]      i_dbg_wdata;
  logic             o_dbg_ack;
  logic             o_dbg_err;
  logic [31:0]      o_dbg_rdata;
  logic             o_dbg_busy;

  modport master (
    output i_dbg_halted, i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    input  o_dbg_ack, o_dbg_err, o_dbg_rdata, o_dbg_busy
  );

  modport slave (
    input  i_dbg_halted, i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    output o_dbg_ack, o_dbg_err, o_dbg_rdata, o_dbg_busy
  );
endinterface

// File: rtl/serv_rf_dbg_arb.sv
// Arbiter between the core's bit-serial RF port and the RF RAM, running debug GPR/CSR accesses
// as serial RF transactions while the core is halted. Define SERV_DBG_CSR_EN to allow CSR targets.
module serv_rf_dbg_arb #(
  parameter int TIMEOUT = 255,
  parameter int RF_AW   = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  // core side
  input  logic             i_core_rreq,
  input  logic             i_core_wreq,
  input  logic [RF_AW-1:0] i_core_wreg0,
  input  logic [RF_AW-1:0] i_core_wreg1,
  input  logic             i_core_wen0,
  input  logic             i_core_wen1,
  input  logic             i_core_wdata0,
  input  logic             i_core_wdata1,
  input  logic [RF_AW-1:0] i_core_rreg0,
  input  logic [RF_AW-1:0] i_core_rreg1,
  output logic             o_core_ready,
  // debug side
  serv_rf_dbg_arb_if.slave dbg,
  // RF RAM side
  output logic             o_rf_rreq,
  output logic             o_rf_wreq,
  output logic [RF_AW-1:0] o_rf_wreg0,
  output logic [RF_AW-1:0] o_rf_wreg1,
  output logic [RF_AW-1:0] o_rf_rreg0,
  output logic [RF_AW-1:0] o_rf_rreg1,
  output logic             o_rf_wen0,
  output logic             o_rf_wen1,
  output logic             o_rf_wdata0,
  output logic             o_rf_wdata1,
  input  logic             i_rf_ready,
  input  logic             i_rf_rdata1
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_RREQ, S_WAIT, S_XFER, S_DONE} state_t;

  state_t           state, state_d;
  logic [TW-1:0]    tcnt;
  logic [4:0]       bcnt;
  logic [31:0]      shreg;
  logic [RF_AW-1:0] addr_q;
  logic             we_q;
  logic             err_q;
  logic             pend_rreq, pend_wreq;
  logic [31:0]      rdata_q;
  logic             grant;
  logic             csr_blocked;

`ifdef SERV_DBG_CSR_EN
  assign csr_blocked = 1'b0;
`else
  // CSR targets are refused without touching the RF.
  assign csr_blocked = dbg.i_dbg_addr[5];
`endif

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state;
    grant        = 1'b0;
    o_core_ready = 1'b0;
    o_rf_rreq    = (state == S_RREQ);
    o_rf_wreq    = 1'b0;
    o_rf_wreg0   = addr_q;
    o_rf_wreg1   = addr_q;
    o_rf_rreg0   = addr_q;
    o_rf_rreg1   = addr_q;
    o_rf_wen0    = (state == S_XFER) && we_q && (addr_q != '0);
    o_rf_wen1    = 1'b0;
    o_rf_wdata0  = shreg[0];
    o_rf_wdata1  = 1'b0;

    case (state)
      S_IDLE: begin
        o_core_ready = i_rf_ready;
        o_rf_rreq    = i_core_rreq | pend_rreq;
        o_rf_wreq    = i_core_wreq | pend_wreq;
        o_rf_wreg0   = i_core_wreg0;
        o_rf_wreg1   = i_core_wreg1;
        o_rf_rreg0   = i_core_rreg0;
        o_rf_rreg1   = i_core_rreg1;
        o_rf_wen0    = i_core_wen0;
        o_rf_wen1    = i_core_wen1;
        o_rf_wdata0  = i_core_wdata0;
        o_rf_wdata1  = i_core_wdata1;
        // Core traffic, live or replayed, always wins the IDLE cycle.
        if (dbg.i_dbg_req && dbg.i_dbg_halted && !i_core_rreq && !i_core_wreq &&
            !pend_rreq && !pend_wreq) begin
          grant   = 1'b1;
          state_d = csr_blocked ? S_DONE : S_RREQ;
        end
      end
      S_RREQ: state_d = S_WAIT;
      S_WAIT: begin
        if (i_rf_ready)                          state_d = S_XFER;
        else if (tcnt == TW'(TIMEOUT - 1))       state_d = S_DONE;
      end
      S_XFER: if (bcnt == 5'd31) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      pend_rreq <= 1'b0;
      pend_wreq <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= state_d;

      if (state == S_IDLE) begin
        pend_rreq <= 1'b0;
        pend_wreq <= 1'b0;
      end else begin
        pend_rreq <= pend_rreq | i_core_rreq;
        pend_wreq <= pend_wreq | i_core_wreq;
      end

      case (state)
        S_IDLE: if (grant) begin
          addr_q <= dbg.i_dbg_addr;
          we_q   <= dbg.i_dbg_we;
          shreg  <= dbg.i_dbg_wdata;
          err_q  <= csr_blocked;
          tcnt   <= '0;
          bcnt   <= '0;
          if (csr_blocked) rdata_q <= '0;
        end
        S_WAIT: begin
          tcnt <= tcnt + 1'b1;
          bcnt <= '0;
          if (!i_rf_ready && tcnt == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        S_XFER: begin
          // Write data leaves from bit 0 while read data enters at bit 31; after 32 shifts
          // the register holds the word read from port 1.
          bcnt  <= bcnt + 1'b1;
          shreg <= {i_rf_rdata1, shreg[31:1]};
          if (bcnt == 5'd31)
            rdata_q <= (addr_q == '0) ? 32'd0 : {i_rf_rdata1, shreg[31:1]};
        end
        default: ;
      endcase
    end
  end

  assign dbg.o_dbg_ack   = (state == S_DONE);
  assign dbg.o_dbg_err   = (state == S_DONE) && err_q;
  assign dbg.o_dbg_rdata = rdata_q;
  assign dbg.o_dbg_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_serv_rf_dbg_arb.sv
// Testbench for serv_rf_dbg_arb: a table of directed debug accesses, a randomized run against a
// word-level register model, and hand sequences for reset mid-transfer.
module tb_serv_rf_dbg_arb;
  localparam int RF_AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             i_rst;
  logic             i_core_rreq, i_core_wreq;
  logic [RF_AW-1:0] i_core_wreg0, i_core_wreg1, i_core_rreg0, i_core_rreg1;
  logic             i_core_wen0, i_core_wen1, i_core_wdata0, i_core_wdata1;
  logic             o_core_ready;
  logic             o_rf_rreq, o_rf_wreq;
  logic [RF_AW-1:0] o_rf_wreg0, o_rf_wreg1, o_rf_rreg0, o_rf_rreg1;
  logic             o_rf_wen0, o_rf_wen1, o_rf_wdata0, o_rf_wdata1;
  logic             i_rf_ready, i_rf_rdata1;

  serv_rf_dbg_arb_if #(.RF_AW(RF_AW)) dbg_if ();

  serv_rf_dbg_arb #(.TIMEOUT(8), .RF_AW(RF_AW)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_core_rreq(i_core_rreq), .i_core_wreq(i_core_wreq),
    .i_core_wreg0(i_core_wreg0), .i_core_wreg1(i_core_wreg1),
    .i_core_wen0(i_core_wen0), .i_core_wen1(i_core_wen1),
    .i_core_wdata0(i_core_wdata0), .i_core_wdata1(i_core_wdata1),
    .i_core_rreg0(i_core_rreg0), .i_core_rreg1(i_core_rreg1),
    .o_core_ready(o_core_ready),
    .dbg(dbg_if),
    .o_rf_rreq(o_rf_rreq), .o_rf_wreq(o_rf_wreq),
    .o_rf_wreg0(o_rf_wreg0), .o_rf_wreg1(o_rf_wreg1),
    .o_rf_rreg0(o_rf_rreg0), .o_rf_rreg1(o_rf_rreg1),
    .o_rf_wen0(o_rf_wen0), .o_rf_wen1(o_rf_wen1),
    .o_rf_wdata0(o_rf_wdata0), .o_rf_wdata1(o_rf_wdata1),
    .i_rf_ready(i_rf_ready), .i_rf_rdata1(i_rf_rdata1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask

  // RF RAM model: ready rf_lat cycles after a read request, then 32 serial bit-cycles.
  logic [31:0] rf_mem [64];
  logic [31:0] ref_mem [64];
  int rf_lat  = 2;
  bit rf_dead = 1'b0;
  int rq_age  = -1;
  int xbit    = -1;

  always @(negedge clk) begin
    i_rf_ready  = 1'b0;
    i_rf_rdata1 = 1'b0;
    if (xbit >= 0) begin
      i_rf_rdata1 = rf_mem[o_rf_rreg1][xbit];
      if (o_rf_wen0) rf_mem[o_rf_wreg0][xbit] = o_rf_wdata0;
      xbit = (xbit == 31) ? -1 : xbit + 1;
    end
    if (o_rf_rreq) rq_age = 0;
    else if (rq_age >= 0) rq_age++;
    if (rq_age == rf_lat && !rf_dead) begin
      i_rf_ready = 1'b1;
      rq_age     = -1;
      xbit       = 0;
    end
  end

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    int          lat;
    bit          dead;
    int          pulse_at;
    int          drop_at;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_busy;
    int          exp_rreq;
    int          exp_wen;
    logic        exp_idle_rreq;
  } vec_t;

  typedef struct {
    logic        got;
    logic        err;
    logic [31:0] rd;
    int          busy_n;
    int          rreq_n;
    int          wen_n;
    int          wen1_n;
    int          rdy_busy_n;
    logic [31:0] ws;
    logic        idle_rreq;
    logic        busy_after;
    logic        rdy_after;
  } res_t;

  task automatic run_access(input vec_t v, output res_t r);
    r = '{default: '0};
    rf_lat  = v.lat;
    rf_dead = v.dead;
    dbg_if.i_dbg_we    = v.we;
    dbg_if.i_dbg_addr  = v.addr;
    dbg_if.i_dbg_wdata = v.wdata;
    dbg_if.i_dbg_req   = 1'b1;
    for (int k = 0; k < 400; k++) begin
      i_core_rreq = (k == v.pulse_at);
      if (k == v.drop_at) begin
        dbg_if.i_dbg_req    = 1'b0;
        dbg_if.i_dbg_halted = 1'b0;
      end
      mid();
      if (dbg_if.o_dbg_busy) begin
        r.busy_n++;
        if (o_core_ready) r.rdy_busy_n++;
      end
      if (o_rf_rreq) r.rreq_n++;
      if (o_rf_wen1) r.wen1_n++;
      if (o_rf_wen0) begin
        r.wen_n++;
        r.ws = {o_rf_wdata0, r.ws[31:1]};
      end
      if (dbg_if.o_dbg_ack) begin
        r.got = 1'b1;
        r.err = dbg_if.o_dbg_err;
        r.rd  = dbg_if.o_dbg_rdata;
        break;
      end
      step();
    end
    step();
    dbg_if.i_dbg_req    = 1'b0;
    dbg_if.i_dbg_halted = 1'b1;
    i_core_rreq         = 1'b0;
    mid();
    r.idle_rreq  = o_rf_rreq;
    r.busy_after = dbg_if.o_dbg_busy;
    for (int j = 0; j < 4; j++) begin
      step();
      mid();
      if (o_core_ready) r.rdy_after = 1'b1;
    end
    rf_dead = 1'b0;
    for (int j = 0; j < 40; j++) step();
  endtask

  task automatic check_res(input string p, input vec_t v, input res_t r);
    check({p, ".ack"},        r.got, 1'b1);
    check({p, ".err"},        r.err, v.exp_err);
    check({p, ".busy_cyc"},   r.busy_n, v.exp_busy);
    check({p, ".rreq_cnt"},   r.rreq_n, v.exp_rreq);
    check({p, ".wen0_cnt"},   r.wen_n, v.exp_wen);
    check({p, ".wen1_cnt"},   r.wen1_n, 0);
    check({p, ".core_rdy"},   r.rdy_busy_n, 0);
    check({p, ".idle_rreq"},  r.idle_rreq, v.exp_idle_rreq);
    check({p, ".rdy_follow"}, r.rdy_after, v.exp_idle_rreq);
    check({p, ".busy_drop"},  r.busy_after, 1'b0);
    if (!v.we)             check({p, ".rdata"},  r.rd, v.exp_rdata);
    if (v.exp_wen == 32)   check({p, ".wstream"}, r.ws, v.wdata);
  endtask

  function automatic bit csr_refused(input logic [5:0] a);
`ifdef SERV_DBG_CSR_EN
    return 1'b0;
`else
    return a[5];
`endif
  endfunction

  vec_t vecs [10];
  res_t res;
  int   acks;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1;
    i_core_rreq = 1'b0; i_core_wreq = 1'b0;
    i_core_wreg0 = '0; i_core_wreg1 = '0; i_core_rreg0 = '0; i_core_rreg1 = '0;
    i_core_wen0 = 1'b0; i_core_wen1 = 1'b0; i_core_wdata0 = 1'b0; i_core_wdata1 = 1'b0;
    dbg_if.i_dbg_halted = 1'b1;
    dbg_if.i_dbg_req    = 1'b0;
    dbg_if.i_dbg_we     = 1'b0;
    dbg_if.i_dbg_addr   = '0;
    dbg_if.i_dbg_wdata  = '0;
    for (int i = 0; i < 64; i++) begin
      rf_mem[i]  = $urandom;
      ref_mem[i] = rf_mem[i];
    end
    rf_mem[5]     = 32'hDEADBEEF; ref_mem[5]     = 32'hDEADBEEF;
    rf_mem[6'h21] = 32'hCAFEF00D; ref_mem[6'h21] = 32'hCAFEF00D;

    repeat (3) step();
    i_rst = 1'b0;
    mid();
    check("reset.busy",  dbg_if.o_dbg_busy, 1'b0);
    check("reset.ack",   dbg_if.o_dbg_ack, 1'b0);
    check("reset.err",   dbg_if.o_dbg_err, 1'b0);
    check("reset.rdata", dbg_if.o_dbg_rdata, 32'd0);
    step();
    i_core_wen0 = 1'b1; i_core_wreg0 = 6'h2A; i_core_rreg0 = 6'h13;
    mid();
    check("pass.wen0",  o_rf_wen0, 1'b1);
    check("pass.wreg0", o_rf_wreg0, 6'h2A);
    check("pass.rreg0", o_rf_rreg0, 6'h13);
    step();
    i_core_wen0 = 1'b0; i_core_wreg0 = '0; i_core_rreg0 = '0;

    //           we    addr   wdata         lat dead pulse drop err   rdata          busy rreq wen idle
    vecs[0] = '{1'b0, 6'd5,  32'd0,         2,  0,   -1,   -1,  1'b0, 32'hDEADBEEF,  36,  1,   0,  1'b0};
    vecs[1] = '{1'b1, 6'd7,  32'h12345678,  2,  0,   -1,   -1,  1'b0, 32'd0,         36,  1,   32, 1'b0};
    vecs[2] = '{1'b0, 6'd7,  32'd0,         3,  0,   -1,   -1,  1'b0, 32'h12345678,  37,  1,   0,  1'b0};
    vecs[3] = '{1'b1, 6'd0,  32'hFFFFFFFF,  1,  0,   -1,   -1,  1'b0, 32'd0,         35,  1,   0,  1'b0};
    vecs[4] = '{1'b0, 6'd0,  32'd0,         1,  0,   -1,   -1,  1'b0, 32'd0,         35,  1,   0,  1'b0};
    vecs[5] = '{1'b0, 6'd5,  32'd0,         2,  0,   20,   -1,  1'b0, 32'hDEADBEEF,  36,  1,   0,  1'b1};
    vecs[6] = '{1'b0, 6'd5,  32'd0,         4,  0,   -1,   3,   1'b0, 32'hDEADBEEF,  38,  1,   0,  1'b0};
    vecs[7] = '{1'b0, 6'd9,  32'd0,         2,  1,   -1,   -1,  1'b1, 32'd0,         10,  1,   0,  1'b0};
    vecs[8] = '{1'b0, 6'd7,  32'd0,         1,  0,   -1,   -1,  1'b0, 32'h12345678,  35,  1,   0,  1'b0};
`ifdef SERV_DBG_CSR_EN
    vecs[9] = '{1'b0, 6'h21, 32'd0,         2,  0,   -1,   -1,  1'b0, 32'hCAFEF00D,  36,  1,   0,  1'b0};
`else
    vecs[9] = '{1'b0, 6'h21, 32'd0,         2,  0,   -1,   -1,  1'b1, 32'd0,         1,   0,   0,  1'b0};
`endif

    for (int i = 0; i < 10; i++) begin
      run_access(vecs[i], res);
      check_res($sformatf("vec%0d", i), vecs[i], res);
      if (vecs[i].we && vecs[i].exp_wen == 32) ref_mem[vecs[i].addr] = vecs[i].wdata;
    end

    // Randomized accesses against the word-level register model.
    for (int i = 0; i < 30; i++) begin
      vec_t v;
      bit   refused;
      v.we       = 1'($urandom_range(0, 1));
      v.addr     = ($urandom_range(0, 7) == 0) ? 6'(32 + $urandom_range(0, 31))
                                                 : 6'($urandom_range(0, 31));
      v.wdata    = $urandom;
      v.lat      = $urandom_range(1, 6);
      v.dead     = 1'b0;
      v.pulse_at = -1;
      v.drop_at  = -1;
      refused    = csr_refused(v.addr);
      v.exp_err  = refused;
      v.exp_rdata = (refused || v.addr == 0) ? 32'd0 : ref_mem[v.addr];
      v.exp_busy = refused ? 1 : 34 + v.lat;
      v.exp_rreq = refused ? 0 : 1;
      v.exp_wen  = (v.we && !refused && v.addr != 0) ? 32 : 0;
      v.exp_idle_rreq = 1'b0;
      run_access(v, res);
      check_res($sformatf("rnd%0d", i), v, res);
      if (v.exp_wen == 32) ref_mem[v.addr] = v.wdata;
    end

    // Reset while XFER is at bit 10: idle next cycle, no ack ever follows.
    rf_lat = 2;
    dbg_if.i_dbg_we   = 1'b0;
    dbg_if.i_dbg_addr = 6'd5;
    dbg_if.i_dbg_req  = 1'b1;
    for (int k = 0; k < 14; k++) begin
      mid();
      step();
    end
    i_rst = 1'b1;
    mid();
    check("rst.busy_before", dbg_if.o_dbg_busy, 1'b1);
    step();
    i_rst = 1'b0;
    dbg_if.i_dbg_req = 1'b0;
    mid();
    check("rst.busy_after", dbg_if.o_dbg_busy, 1'b0);
    check("rst.ack_after",  dbg_if.o_dbg_ack, 1'b0);
    acks = 0;
    for (int j = 0; j < 40; j++) begin
      step();
      mid();
      if (dbg_if.o_dbg_ack) acks++;
    end
    check("rst.no_ack", acks, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serv_rf_dbg_arb.md
Name: serv_rf_dbg_arb

Overview:
Arbiter/sequencer placed between the core's bit-serial RF interface and the RF RAM interface. It passes core traffic through, and lets the debug module read or write one 32-bit GPR/CSR word while the core is halted. Each debug access is run as a normal serial RF transaction: request, wait for ready, then 32 bit-cycles LSB first. Debug writes use write port 0; debug reads use read port 1.

Parameters:
TIMEOUT, 255, maximum cycles spent in WAIT for i_rf_ready before the access aborts with an error
RF_AW, 6, RF address width (GPRs at 0-31, CSRs at bit5=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_core_rreq  in  1  core RF read request pulse
i_core_wreq  in  1  core RF write request pulse
i_core_wreg0/i_core_wreg1  in  RF_AW  core write addresses
i_core_wen0/i_core_wen1  in  1  core write enables
i_core_wdata0/i_core_wdata1  in  1  core serial write data
i_core_rreg0/i_core_rreg1  in  RF_AW  core read addresses
o_core_ready  out  1  RF ready, forwarded to the core
i_dbg_halted  in  1  core is halted
i_dbg_req  in  1  debug access request, level; held until o_dbg_ack
i_dbg_we  in  1  1 = write, 0 = read
i_dbg_addr  in  RF_AW  target register
i_dbg_wdata  in  32  write data
o_dbg_ack  out  1  one-cycle completion pulse
o_dbg_err  out  1  valid with o_dbg_ack
o_dbg_rdata  out  32  read result
o_dbg_busy  out  1  arbiter owned by debug
o_rf_rreq/o_rf_wreq  out  1  to RF
o_rf_wreg0/o_rf_wreg1/o_rf_rreg0/o_rf_rreg1  out  RF_AW  to RF
o_rf_wen0/o_rf_wen1/o_rf_wdata0/o_rf_wdata1  out  1  to RF
i_rf_ready  in  1  RF ready
i_rf_rdata1  in  1  RF serial read data, port 1

Behaviour:
- States: IDLE, RREQ, WAIT, XFER, DONE. On reset: state IDLE, all counters 0, pending flag 0, o_dbg_rdata 0, o_dbg_ack/err/busy 0.
- IDLE: all core signals pass through combinationally and o_core_ready = i_rf_ready.
- Grant: enter RREQ when all of these hold in IDLE: i_dbg_req, i_dbg_halted, no core rreq/wreq this cycle, pending flag clear. Latch addr, we and wdata into a 32-bit shift register on grant.
- RREQ: drive o_rf_rreq=1 for one cycle. Drive o_rf_rreg1 = o_rf_wreg0 = latched addr from RREQ through XFER. Next state WAIT.
- WAIT: increment the timeout counter.
  - On i_rf_ready: go to XFER with cnt=0.
  - When the counter reaches TIMEOUT-1 with no ready: go to DONE with err=1 and rdata=0.
- XFER: 32 cycles, 5-bit cnt.
  - Each cycle: o_rf_wdata0 = shreg[0]; o_rf_wen0 = we & (addr != 0).
  - Shift i_rf_rdata1 into the read register MSB-side (right shift), so bit 0 arrives first.
  - cnt==31 -> DONE.
  - Write port 1 enable is held at 0.
- DONE: o_dbg_ack=1 for one cycle and o_dbg_err valid. o_dbg_rdata is updated (0 for addr 0 or on error) and held until the next grant. Then IDLE.
- o_dbg_busy=1 in every state except IDLE.
- While not IDLE: o_core_ready=0, core wen0/wen1 are blocked, and core address outputs are overridden.
  - A core rreq/wreq pulse arriving while busy sets the pending flag.
  - On return to IDLE the pending request is reissued to the RF for one cycle and the flag is cleared. Debug is not granted that cycle.
- i_dbg_halted falling mid-access: the access still completes.
- i_dbg_req dropped before ack: the access still completes and the ack is issued.
- Reset mid-access: immediate return to IDLE. A partial write may remain in the RF; this is accepted.

Optional Feature:
SERV_DBG_CSR_EN.
- Defined: addresses with bit5=1 (CSRs) are accessed normally.
- Undefined: a request with addr[5]=1 goes IDLE->DONE with no RF activity, o_dbg_err=1, rdata=0.

Test Plan:
1. Halted, read addr 5 holding 0xDEADBEEF, ready 2 cycles after rreq -> one rreq pulse, 32 XFER cycles, ack with rdata=0xDEADBEEF, err=0.
2. Write addr 7, data 0x12345678 -> wen0 high for exactly 32 cycles, wdata0 stream LSB first; readback returns 0x12345678.
3. Write addr 0, data 0xFFFFFFFF -> wen0 never asserted, ack, err=0; a following read returns 0.
4. i_rf_ready tied low, TIMEOUT=8 -> ack 8 cycles after entering WAIT, err=1, rdata=0, busy drops the cycle after ack.
5. Core rreq pulse during XFER -> o_core_ready stays 0; rreq reissued in the first IDLE cycle, core ready follows RF.
6. i_rst asserted at XFER cnt=10 -> next cycle IDLE, busy=0, no ack. Without SERV_DBG_CSR_EN, a read of addr 0x21 -> ack+err with no rreq.
